// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Contents: FSM state enum, ALU operation codes, data-processing command
// codes, condition codes, ResultSrc/ALUSrcB/Op encodings.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_EOR = 3'b100,
        ALU_MOV = 3'b101
    } alu_op_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_t;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/arm_mc_controller_if.sv
// Bundle between instruction register / ALU and the control unit.
// master: control unit (takes instruction fields + ALU flags, drives
//         datapath enables, mux selects, ALUControl, Flags, Undef).
// slave : datapath side, the mirror image.
interface arm_mc_controller_if #(
    parameter int unsigned ALU_CTRL_W = 3
);
    logic [3:0]            Cond;
    logic [1:0]            Op;
    logic [5:0]            Funct;
    logic [3:0]            Rd;
    logic [3:0]            ALUFlags;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemW;
    logic                  IRWrite;
    logic                  RegW;
    logic [1:0]            ResultSrc;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [1:0]            ImmSrc;
    logic [1:0]            RegSrc;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic [3:0]            Flags;
    logic                  Undef;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags, Undef
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags, Undef
    );
endinterface

// File: rtl/arm_mc_controller_cond_check.sv
// ARM condition evaluation (combinational).
// cond_i    : Instr[31:28]
// flags_i   : architectural {N,Z,C,V}
// cond_ex_o : 1 when the instruction executes; 1111 never executes.
module cond_check
    import arm_mc_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main FSM, ALU command decode, condition
// latch and NZCV flag register.
// clk   : rising-edge clock
// reset : asynchronous, active-low; write enables are held low while asserted
// bus   : instruction fields/ALU flags in, datapath controls/Flags/Undef out
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3,
    parameter int unsigned PC_REG     = 15
)(
    input  logic                   clk,
    input  logic                   reset,
    arm_mc_controller_if.master    bus
);
    localparam logic [3:0] PC_IDX = 4'(PC_REG);

    state_t     state_q, state_d;
    logic       cond_ex_q, cond_ex_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ok;

    cond_check u_cond (
        .cond_i    (bus.Cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ok)
    );

    logic [3:0] cmd;
    logic       s_bit, i_bit;
    assign cmd   = bus.Funct[4:1];
    assign s_bit = bus.Funct[0];
    assign i_bit = bus.Funct[5];

    alu_op_t dp_op;
    logic    supported, no_write, cv_upd;

    always_comb begin
        dp_op     = ALU_ADD;
        supported = 1'b1;
        no_write  = 1'b0;
        cv_upd    = 1'b0;
        case (cmd)
            CMD_ADD: begin dp_op = ALU_ADD; cv_upd = 1'b1; end
            CMD_SUB: begin dp_op = ALU_SUB; cv_upd = 1'b1; end
            CMD_AND: dp_op = ALU_AND;
            CMD_ORR: dp_op = ALU_ORR;
            CMD_EOR: begin dp_op = ALU_EOR; supported = (ALU_CTRL_W >= 3); end
            CMD_MOV: begin dp_op = ALU_MOV; supported = (ALU_CTRL_W >= 3); end
            // CMP only exists in its flag-setting form
            CMD_CMP: begin dp_op = ALU_SUB; no_write = 1'b1; cv_upd = 1'b1; supported = s_bit; end
            default: supported = 1'b0;
        endcase
        if (!supported) dp_op = ALU_ADD;
    end

    logic       pc_write, adr_src, mem_w, ir_write, reg_w, alu_src_a, undef;
    logic [1:0] result_src, alu_src_b;
    alu_op_t    alu_op;

    always_comb begin
        state_d    = state_q;
        cond_ex_d  = cond_ex_q;
        flags_d    = flags_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_w      = 1'b0;
        ir_write   = 1'b0;
        reg_w      = 1'b0;
        alu_src_a  = 1'b0;
        undef      = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALU_ADD;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                pc_write   = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                cond_ex_d  = cond_ok;
                case (bus.Op)
                    OP_DP: begin
                        state_d = i_bit ? EXECI : EXECR;
                        undef   = ~supported;
                    end
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
                    default: begin state_d = FETCH; undef = 1'b1; end
                endcase
            end
            EXECR, EXECI: begin
                if (state_q == EXECI) alu_src_b = SRCB_EXT;
                alu_op  = dp_op;
                state_d = ALUWB;
                // Condition was latched in DECODE from the pre-instruction flags
                if (s_bit && cond_ex_q && supported) begin
                    flags_d[3:2] = bus.ALUFlags[3:2];
                    if (cv_upd) flags_d[1:0] = bus.ALUFlags[1:0];
                end
            end
            ALUWB: begin
                reg_w   = cond_ex_q & ~no_write & supported;
                state_d = FETCH;
            end
            MEMADR: begin
                alu_src_b = SRCB_EXT;
                alu_op    = bus.Funct[3] ? ALU_ADD : ALU_SUB;
                state_d   = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_w      = cond_ex_q;
                state_d    = FETCH;
            end
            MEMWR: begin
                adr_src = 1'b1;
                mem_w   = cond_ex_q;
                state_d = FETCH;
            end
            BRANCH: begin
                alu_src_b  = SRCB_EXT;
                result_src = RES_ALURES;
                pc_write   = cond_ex_q;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (reg_w && (bus.Rd == PC_IDX)) pc_write = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            cond_ex_q <= 1'b0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            cond_ex_q <= cond_ex_d;
            flags_q   <= flags_d;
        end
    end

    // Enables gated by reset so FETCH's PC/IR writes cannot fire while held
    assign bus.PCWrite    = pc_write & reset;
    assign bus.IRWrite    = ir_write & reset;
    assign bus.RegW       = reg_w & reset;
    assign bus.MemW       = mem_w & reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = ALU_CTRL_W'(alu_op);
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.Flags      = flags_q;
    assign bus.Undef      = undef;
endmodule

// File: tb/tb_arm_mc_controller.sv
module tb_arm_mc_controller;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    arm_mc_controller_if #(.ALU_CTRL_W(3)) ifc ();
    arm_mc_controller_if #(.ALU_CTRL_W(2)) ifc2 ();

    arm_mc_controller #(.ALU_CTRL_W(3), .PC_REG(15)) dut (
        .clk(clk), .reset(reset), .bus(ifc.master)
    );
    arm_mc_controller #(.ALU_CTRL_W(2), .PC_REG(15)) dut2 (
        .clk(clk), .reset(reset), .bus(ifc2.master)
    );

    assign ifc2.Cond     = ifc.Cond;
    assign ifc2.Op       = ifc.Op;
    assign ifc2.Funct    = ifc.Funct;
    assign ifc2.Rd       = ifc.Rd;
    assign ifc2.ALUFlags = ifc.ALUFlags;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemW,IRWrite,RegW,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,Undef}
    logic [13:0] ctl, want;
    assign ctl = {ifc.PCWrite, ifc.AdrSrc, ifc.MemW, ifc.IRWrite, ifc.RegW, ifc.ResultSrc,
                  ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUControl, ifc.Undef};

    localparam logic [13:0] C_FETCH   = 14'b1_0_0_1_0_10_1_10_000_0;
    localparam logic [13:0] C_RSTF    = 14'b0_0_0_0_0_10_1_10_000_0;
    localparam logic [13:0] C_DEC     = 14'b0_0_0_0_0_10_1_10_000_0;
    localparam logic [13:0] C_DEC_UND = 14'b0_0_0_0_0_10_1_10_000_1;
    localparam logic [13:0] C_WB      = 14'b0_0_0_0_1_00_0_00_000_0;
    localparam logic [13:0] C_WB_NW   = 14'b0_0_0_0_0_00_0_00_000_0;
    localparam logic [13:0] C_WB_PC   = 14'b1_0_0_0_1_00_0_00_000_0;
    localparam logic [13:0] C_MA_ADD  = 14'b0_0_0_0_0_00_0_01_000_0;
    localparam logic [13:0] C_MA_SUB  = 14'b0_0_0_0_0_00_0_01_001_0;
    localparam logic [13:0] C_MRD     = 14'b0_1_0_0_0_00_0_00_000_0;
    localparam logic [13:0] C_MWB     = 14'b0_0_0_0_1_01_0_00_000_0;
    localparam logic [13:0] C_MWR0    = 14'b0_1_0_0_0_00_0_00_000_0;
    localparam logic [13:0] C_MWR1    = 14'b0_1_1_0_0_00_0_00_000_0;
    localparam logic [13:0] C_BR_T    = 14'b1_0_0_0_0_10_0_01_000_0;
    localparam logic [13:0] C_BR_N    = 14'b0_0_0_0_0_10_0_01_000_0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
        ifc.Cond = c; ifc.Op = o; ifc.Funct = f; ifc.Rd = r;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifc.ALUFlags = 4'b0000;
        set_instr(4'hE, 2'b00, 6'b001000, 4'd1);
        #2;
        want = C_RSTF; total++; if (ctl !== want) begin bad++; $display("FAIL reset_ctl: ctl=%b want=%b", ctl, want); end
        total++; if (ifc.Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags: Flags=%b want=0000", ifc.Flags); end
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    // ADD R1,R2,R3 (E0821003)
    task automatic test_add();
        set_instr(4'hE, 2'b00, 6'b001000, 4'd1);
        want = C_FETCH; total++; if (ctl !== want) begin bad++; $display("FAIL add_fetch: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_DEC; total++; if (ctl !== want) begin bad++; $display("FAIL add_decode: ctl=%b want=%b", ctl, want); end
        tick();
        want = 14'b0_0_0_0_0_00_0_00_000_0; total++; if (ctl !== want) begin bad++; $display("FAIL add_execr: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_WB; total++; if (ctl !== want) begin bad++; $display("FAIL add_aluwb: ctl=%b want=%b", ctl, want); end
        tick();
    endtask

    // SUBS R0,R0,#1 then BEQ
    task automatic test_subs_beq();
        set_instr(4'hE, 2'b00, 6'b100101, 4'd0);
        want = C_FETCH; total++; if (ctl !== want) begin bad++; $display("FAIL subs_fetch: ctl=%b want=%b", ctl, want); end
        tick(); tick();
        ifc.ALUFlags = 4'b0100;
        #1;
        want = 14'b0_0_0_0_0_00_0_01_001_0; total++; if (ctl !== want) begin bad++; $display("FAIL subs_execi: ctl=%b want=%b", ctl, want); end
        tick();
        ifc.ALUFlags = 4'b0000;
        want = C_WB; total++; if (ctl !== want) begin bad++; $display("FAIL subs_aluwb: ctl=%b want=%b", ctl, want); end
        total++; if (ifc.Flags !== 4'b0100) begin bad++; $display("FAIL subs_flags: Flags=%b want=0100", ifc.Flags); end
        tick();
        set_instr(4'h0, 2'b10, 6'b100000, 4'd0);
        total++; if ({ifc.ImmSrc, ifc.RegSrc} !== 4'b10_01) begin bad++; $display("FAIL beq_imm_regsrc: got=%b want=1001", {ifc.ImmSrc, ifc.RegSrc}); end
        tick(); tick();
        want = C_BR_T; total++; if (ctl !== want) begin bad++; $display("FAIL beq_branch: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_FETCH; total++; if (ctl !== want) begin bad++; $display("FAIL beq_3cyc: ctl=%b want=%b", ctl, want); end
    endtask

    task automatic test_bne();
        set_instr(4'h1, 2'b10, 6'b100000, 4'd0);
        tick();
        want = C_DEC; total++; if (ctl !== want) begin bad++; $display("FAIL bne_decode: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_BR_N; total++; if (ctl !== want) begin bad++; $display("FAIL bne_branch: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_FETCH; total++; if (ctl !== want) begin bad++; $display("FAIL bne_3cyc: ctl=%b want=%b", ctl, want); end
    endtask

    // LDR R1,[R2,#4] (E5921004)
    task automatic test_ldr();
        set_instr(4'hE, 2'b01, 6'b011001, 4'd1);
        total++; if ({ifc.ImmSrc, ifc.RegSrc} !== 4'b01_10) begin bad++; $display("FAIL ldr_imm_regsrc: got=%b want=0110", {ifc.ImmSrc, ifc.RegSrc}); end
        tick(); tick();
        want = C_MA_ADD; total++; if (ctl !== want) begin bad++; $display("FAIL ldr_memadr: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_MRD; total++; if (ctl !== want) begin bad++; $display("FAIL ldr_memrd: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_MWB; total++; if (ctl !== want) begin bad++; $display("FAIL ldr_memwb: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_FETCH; total++; if (ctl !== want) begin bad++; $display("FAIL ldr_5cyc: ctl=%b want=%b", ctl, want); end
    endtask

    // CMP R1,R2 (E1510002), then ANDS R1,R1,R2 (NZ only)
    task automatic test_cmp_ands();
        set_instr(4'hE, 2'b00, 6'b010101, 4'd0);
        tick(); tick();
        ifc.ALUFlags = 4'b1001;
        #1;
        want = 14'b0_0_0_0_0_00_0_00_001_0; total++; if (ctl !== want) begin bad++; $display("FAIL cmp_execr: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_WB_NW; total++; if (ctl !== want) begin bad++; $display("FAIL cmp_aluwb: ctl=%b want=%b", ctl, want); end
        total++; if (ifc.Flags !== 4'b1001) begin bad++; $display("FAIL cmp_flags: Flags=%b want=1001", ifc.Flags); end
        tick();
        set_instr(4'hE, 2'b00, 6'b000001, 4'd1);
        tick(); tick();
        ifc.ALUFlags = 4'b0110;
        #1;
        want = 14'b0_0_0_0_0_00_0_00_010_0; total++; if (ctl !== want) begin bad++; $display("FAIL ands_execr: ctl=%b want=%b", ctl, want); end
        tick();
        ifc.ALUFlags = 4'b0000;
        total++; if (ifc.Flags !== 4'b0101) begin bad++; $display("FAIL ands_flags: Flags=%b want=0101", ifc.Flags); end
        tick();
    endtask

    // ADD PC,R1,R2
    task automatic test_add_pc();
        set_instr(4'hE, 2'b00, 6'b001000, 4'hF);
        tick(); tick(); tick();
        want = C_WB_PC; total++; if (ctl !== want) begin bad++; $display("FAIL addpc_aluwb: ctl=%b want=%b", ctl, want); end
        tick();
    endtask

    task automatic test_never_str();
        set_instr(4'hF, 2'b01, 6'b011000, 4'd1);
        tick(); tick();
        want = C_MA_ADD; total++; if (ctl !== want) begin bad++; $display("FAIL nvstr_memadr: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_MWR0; total++; if (ctl !== want) begin bad++; $display("FAIL nvstr_memwr: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_FETCH; total++; if (ctl !== want) begin bad++; $display("FAIL nvstr_4cyc: ctl=%b want=%b", ctl, want); end
    endtask

    task automatic test_undef();
        set_instr(4'hE, 2'b11, 6'b000000, 4'd0);
        tick();
        want = C_DEC_UND; total++; if (ctl !== want) begin bad++; $display("FAIL undef_decode: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_FETCH; total++; if (ctl !== want) begin bad++; $display("FAIL undef_2cyc: ctl=%b want=%b", ctl, want); end
    endtask

    // EOR R1,R2,R3: supported at 3-bit ALUControl, unsupported at 2-bit
    task automatic test_eor_narrow();
        set_instr(4'hE, 2'b00, 6'b000010, 4'd1);
        tick();
        want = C_DEC; total++; if (ctl !== want) begin bad++; $display("FAIL eor3_decode: ctl=%b want=%b", ctl, want); end
        total++; if (ifc2.Undef !== 1'b1) begin bad++; $display("FAIL eor2_undef: Undef=%b want=1", ifc2.Undef); end
        tick();
        want = 14'b0_0_0_0_0_00_0_00_100_0; total++; if (ctl !== want) begin bad++; $display("FAIL eor3_execr: ctl=%b want=%b", ctl, want); end
        total++; if ({ifc2.ALUControl, ifc2.Undef} !== 3'b00_0) begin bad++; $display("FAIL eor2_execr: got=%b want=000", {ifc2.ALUControl, ifc2.Undef}); end
        tick();
        want = C_WB; total++; if (ctl !== want) begin bad++; $display("FAIL eor3_aluwb: ctl=%b want=%b", ctl, want); end
        total++; if ({ifc2.RegW, ifc2.PCWrite} !== 2'b00) begin bad++; $display("FAIL eor2_aluwb: got=%b want=00", {ifc2.RegW, ifc2.PCWrite}); end
        tick();
    endtask

    // STR with U=0, reset pulled low in MEMWR
    task automatic test_reset_mid();
        set_instr(4'hE, 2'b01, 6'b010000, 4'd1);
        tick(); tick();
        want = C_MA_SUB; total++; if (ctl !== want) begin bad++; $display("FAIL strsub_memadr: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_MWR1; total++; if (ctl !== want) begin bad++; $display("FAIL str_memwr: ctl=%b want=%b", ctl, want); end
        reset = 1'b0;
        #1;
        want = C_RSTF; total++; if (ctl !== want) begin bad++; $display("FAIL rstmid_ctl: ctl=%b want=%b", ctl, want); end
        total++; if (ifc.Flags !== 4'b0000) begin bad++; $display("FAIL rstmid_flags: Flags=%b want=0000", ifc.Flags); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        want = C_FETCH; total++; if (ctl !== want) begin bad++; $display("FAIL rstrel_fetch: ctl=%b want=%b", ctl, want); end
        tick();
        want = C_DEC; total++; if (ctl !== want) begin bad++; $display("FAIL rstrel_decode: ctl=%b want=%b", ctl, want); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_subs_beq();
        test_bne();
        test_ldr();
        test_cmp_ands();
        test_add_pc();
        test_never_str();
        test_undef();
        test_eor_narrow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
